keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64, length in clk cycles of each contact-bounce phase (0 = no bounce).
REQ-002 Parameter GAP_CYCLES, default 600, minimum released time in clk cycles after each key release.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cols  input  4  active-low column drive from the scanner; bit c low selects column c.
REQ-006 rows  output  4  active-low row sense returned to the scanner; 4'b1111 = no contact.
REQ-007 press_valid  input  1  press request present.
REQ-008 press_key  input  4  hex key value to press.
REQ-009 press_hold  input  16  stable-contact hold time in clk cycles.
REQ-010 press_ready  output  1  high when a request can be accepted.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when a press sequence completes.

Function
REQ-013 Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D; c0 is leftmost.
REQ-014 Request accepted on a cycle with press_valid && press_ready; press_key and press_hold latched that cycle.
REQ-015 press_ready = (state == IDLE) && !reset.
REQ-016 FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-017 IDLE -> BOUNCE_IN on accept; if BOUNCE_CYCLES = 0, go directly to HOLD.
REQ-018 BOUNCE_IN lasts BOUNCE_CYCLES cycles, then HOLD.
REQ-019 HOLD lasts max(press_hold, 1) cycles, then BOUNCE_OUT (or GAP if BOUNCE_CYCLES = 0).
REQ-020 BOUNCE_OUT lasts BOUNCE_CYCLES cycles, then GAP.
REQ-021 GAP lasts GAP_CYCLES cycles, then IDLE; done asserts on the cycle the FSM returns to IDLE.
REQ-022 Contact rules: closed in HOLD; open in IDLE and GAP; equal to lfsr[0] in BOUNCE_IN and BOUNCE_OUT.
REQ-023 rows registered, one-cycle latency: rows[r] <= 0 iff contact is closed, r is the latched row, and cols[latched col] == 0; otherwise 1.
REQ-024 Several columns low at once: rows follows REQ-023 (single-key wired-AND); columns that are not the latched column have no effect.
REQ-025 LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle; seed 8'hA5.
REQ-026 A press_valid asserted while busy is ignored, not queued.
REQ-027 Phase counters are sized for max(16-bit hold, BOUNCE_CYCLES, GAP_CYCLES) and never wrap within a phase.

Reset
REQ-028 On reset: state = IDLE, rows = 4'b1111, done = 0, busy = 0, LFSR = 8'hA5, counters = 0, latched key = 0.
REQ-029 Reset asserted mid-sequence aborts the sequence; rows = 4'b1111 on the next edge and no done pulse is produced.
REQ-030 press_ready is low while reset is high.

Structure
REQ-031 The shared package keypad_pkg holds the FSM state enum and the key-to-(row,col) mapping constants; the scanner decode uses the same constants.
REQ-032 The LFSR is a sub-module lfsr8 (clk, reset, seed parameter, 8-bit state out).

Verification
REQ-033 BOUNCE_CYCLES = 0, key 5, hold 10, cols = 4'b1101 held -> rows = 4'b1101 for exactly 10 cycles (1-cycle lag), done pulses after GAP_CYCLES more cycles.
REQ-034 Key D, cols stepping through 1110/1101/1011/0111 -> rows = 4'b0111 only while cols = 4'b0111 during HOLD, 4'b1111 otherwise.
REQ-035 Default BOUNCE_CYCLES, key 1, cols = 4'b1110 -> rows[0] matches the delayed lfsr[0] sequence from seed A5 during bounce, is stable 0 in HOLD, and is 1 in GAP.
REQ-036 Second press_valid during HOLD -> ignored; press_ready stays low; exactly one done pulse.
REQ-037 Reset pulse during HOLD -> rows = 4'b1111 next cycle, no done, press_ready high one cycle after reset is released.
REQ-038 End-to-end with the keypad scanner: press A then 7 -> scanner reports val2 = 7 and val1 = 10, each key registered exactly once despite bounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM states, LFSR seed and the
// key <-> (row, col) map used by both the emulator and any scanner decode.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Keypad layout, columns left to right:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  // One {row,col} nibble per key value, key 0 in the least significant nibble.
  localparam logic [63:0] KEY_POS_MAP = 64'hECFB_73A9_8654_210D;

  // Physical position of a hex key.
  function automatic key_pos_t key_pos(input logic [3:0] key);
    return KEY_POS_MAP[{key, 2'b00} +: 4];
  endfunction

  // Inverse lookup for scanner decode: key found at (row, col).
  function automatic logic [3:0] pos_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] key;
    key = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (KEY_POS_MAP[k*4 +: 4] == {row, col}) key = 4'(k);
    end
    return key;
  endfunction

endpackage

// File: rtl/keypad_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free running, used as the bounce source.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] state
);

  logic feedback;

  // Feedback from taps 8,6,5,4 (bits 7,5,4,3).
  always_comb begin
    feedback = state[7] ^ state[5] ^ state[4] ^ state[3];
  end

  // Advance every cycle; reload the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= {state[6:0], feedback};
  end

endmodule

// File: rtl/keypad_emulator.sv
// Matrix keypad emulator: presses one requested key with contact bounce on
// make and break, a stable hold, and a mandatory released gap afterwards.
// Row sense is returned through a one-cycle register against the column drive.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GAP_CYCLES    = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  input  logic        press_valid,
  input  logic [3:0]  press_key,
  input  logic [15:0] press_hold,
  output logic        press_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HOLD_MAX = 65535;
  localparam int unsigned BG_MAX   = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (HOLD_MAX > BG_MAX) ? HOLD_MAX : BG_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  // A zero-length gap still occupies one cycle so GAP is always observable.
  localparam int unsigned GAP_LEN  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam bit          HAS_BOUNCE = (BOUNCE_CYCLES != 0);
  // Bounce states are unreachable when BOUNCE_CYCLES is 0, so the wrapped value is harmless.
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_last;
  logic [3:0]       key_q;
  logic [15:0]      hold_q;
  logic [7:0]       lfsr;
  logic             accept;
  logic             phase_last;
  logic             contact;
  key_pos_t         pos;
  logic             unused_lfsr_hi;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Only bit 0 drives the bounce pattern; the rest is the LFSR's internal history.
  assign unused_lfsr_hi = ^lfsr[7:1];

  assign accept    = press_valid && press_ready;
  assign pos       = key_pos(key_q);
  assign hold_last = CNT_W'((hold_q == 16'd0) ? 16'd0 : (hold_q - 16'd1));

  // Latch the requested key and hold time when a request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      hold_q <= '0;
    end else if (accept) begin
      key_q  <= press_key;
      hold_q <= press_hold;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Final cycle of the current timed phase.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      BOUNCE_IN, BOUNCE_OUT: phase_last = (cnt == BOUNCE_LAST);
      HOLD:                  phase_last = (cnt == hold_last);
      GAP:                   phase_last = (cnt == GAP_LAST);
      default:               phase_last = 1'b0;
    endcase
  end

  // Next-state logic; bounce phases are skipped entirely when BOUNCE_CYCLES is 0.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept)     state_next = HAS_BOUNCE ? BOUNCE_IN : HOLD;
      BOUNCE_IN:  if (phase_last) state_next = HOLD;
      HOLD:       if (phase_last) state_next = HAS_BOUNCE ? BOUNCE_OUT : GAP;
      BOUNCE_OUT: if (phase_last) state_next = GAP;
      GAP:        if (phase_last) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Phase counter: restarts at every phase entry, counts while busy.
  always_ff @(posedge clk) begin
    if (reset)                     cnt <= '0;
    else if (accept || phase_last) cnt <= '0;
    else if (state != IDLE)        cnt <= cnt + CNT_W'(1);
  end

  // Status outputs and contact closure for the current state.
  always_comb begin
    busy        = (state != IDLE);
    press_ready = (state == IDLE) && !reset;
    case (state)
      HOLD:                  contact = 1'b1;
      BOUNCE_IN, BOUNCE_OUT: contact = lfsr[0];
      default:               contact = 1'b0;
    endcase
  end

  // Registered row sense; only the latched key's column can pull its row low.
  always_ff @(posedge clk) begin
    if (reset)                         rows <= '1;
    else if (contact && !cols[pos.col]) rows <= ~(4'b0001 << pos.row);
    else                               rows <= '1;
  end

  // Completion pulse, visible on the first IDLE cycle after GAP.
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= (state == GAP) && phase_last;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: two instances (with and without
// bounce) compared cycle by cycle against a timeline model of the press.
module tb_keypad_emulator;

  localparam int B0 = 64;
  localparam int G0 = 600;
  localparam int B1 = 0;
  localparam int G1 = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cols;
  logic        pv      [2];
  logic [3:0]  pk      [2];
  logic [15:0] ph      [2];
  logic [3:0]  rows_o  [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic        done_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(B0), .GAP_CYCLES(G0)) u_dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows_o[0]),
    .press_valid(pv[0]), .press_key(pk[0]), .press_hold(ph[0]),
    .press_ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  keypad_emulator #(.BOUNCE_CYCLES(B1), .GAP_CYCLES(G1)) u_dut_nb (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows_o[1]),
    .press_valid(pv[1]), .press_key(pk[1]), .press_hold(ph[1]),
    .press_ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  // ---------------- reference model ----------------
  // Physical layout, index = row*4 + col.
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  logic [7:0] m_lfsr;
  bit         m_act  [2];
  int         m_off  [2];
  int         m_key  [2];
  int         m_hold [2];
  logic [3:0] m_rows [2];
  logic       m_done [2];

  function automatic int bc(input int d);
    return (d == 0) ? B0 : B1;
  endfunction

  function automatic int gc(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic void key_rc(input int key, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 16; i++) if (layout[i] == key) begin r = i / 4; c = i % 4; end
  endfunction

  // Contact state at offset m_off into the press timeline.
  function automatic bit m_contact(input int d);
    int b, h, o;
    if (!m_act[d]) return 1'b0;
    b = bc(d); h = m_hold[d]; o = m_off[d];
    if (o < b)         return m_lfsr[0];
    if (o < b + h)     return 1'b1;
    if (o < 2 * b + h) return m_lfsr[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_rows_next(input int d);
    int r, c;
    key_rc(m_key[d], r, c);
    if (m_contact(d) && cols[c] == 1'b0) return ~(4'b0001 << r);
    return 4'hF;
  endfunction

  always @(posedge clk) begin
    m_lfsr <= reset ? 8'hA5 : lfsr_next(m_lfsr);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d]  <= 1'b0;
        m_rows[d] <= 4'hF;
        m_done[d] <= 1'b0;
      end else begin
        m_rows[d] <= model_rows_next(d);
        m_done[d] <= 1'b0;
        if (m_act[d]) begin
          if (m_off[d] + 1 == 2 * bc(d) + m_hold[d] + gc(d)) begin
            m_act[d]  <= 1'b0;
            m_done[d] <= 1'b1;
          end else begin
            m_off[d] <= m_off[d] + 1;
          end
        end else if (pv[d]) begin
          m_act[d]  <= 1'b1;
          m_off[d]  <= 0;
          m_key[d]  <= int'(pk[d]);
          m_hold[d] <= (ph[d] == 16'd0) ? 1 : int'(ph[d]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (rows_o[d] !== 4'hF) begin n_fail++; $display("FAIL reset_rows d=%0d got=%b exp=1111", d, rows_o[d]); end
      n_checks++; if (busy_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d=%0d got=%b exp=0", d, busy_o[d]); end
      n_checks++; if (done_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done d=%0d got=%b exp=0", d, done_o[d]); end
      n_checks++; if (ready_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low d=%0d got=%b exp=0", d, ready_o[d]); end
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high d=%0d got=%b exp=1", d, ready_o[d]); end
    end
  endtask

  task automatic test_no_bounce();
    int low_cnt = 0, first_low = -1, done_cnt = 0, done_k = -1;
    cols = 4'b1101; pk[1] = 4'h5; ph[1] = 16'd10; pv[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n_checks++; if (rows_o[1] !== m_rows[1]) begin n_fail++; $display("FAIL nobounce_rows k=%0d got=%b exp=%b", k, rows_o[1], m_rows[1]); end
      n_checks++; if (done_o[1] !== m_done[1]) begin n_fail++; $display("FAIL nobounce_done k=%0d got=%b exp=%b", k, done_o[1], m_done[1]); end
      n_checks++; if (busy_o[1] !== m_act[1]) begin n_fail++; $display("FAIL nobounce_busy k=%0d got=%b exp=%b", k, busy_o[1], m_act[1]); end
      if (rows_o[1] == 4'b1101) begin low_cnt++; if (first_low < 0) first_low = k; end
      if (done_o[1] === 1'b1) begin done_cnt++; done_k = k; end
      tick();
    end
    n_checks++; if (low_cnt != 10) begin n_fail++; $display("FAIL nobounce_low_count got=%0d exp=10", low_cnt); end
    n_checks++; if (first_low != 1) begin n_fail++; $display("FAIL nobounce_latency got=%0d exp=1", first_low); end
    n_checks++; if (done_cnt != 1 || done_k != 10 + G1) begin n_fail++; $display("FAIL nobounce_done_time got=%0d@%0d exp=1@%0d", done_cnt, done_k, 10 + G1); end
  endtask

  task automatic test_col_sweep();
    logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int low_cnt = 0, bad_cnt = 0;
    pk[1] = 4'hD; ph[1] = 16'd40; pv[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    for (int k = 0; k < 70; k++) begin
      n_checks++; if (rows_o[1] !== m_rows[1]) begin n_fail++; $display("FAIL sweep_rows k=%0d got=%b exp=%b", k, rows_o[1], m_rows[1]); end
      if (rows_o[1] == 4'b0111) low_cnt++;
      else if (rows_o[1] != 4'hF) bad_cnt++;
      cols = pat[(k / 3) % 4];
      tick();
    end
    n_checks++; if (low_cnt != 9) begin n_fail++; $display("FAIL sweep_low_count got=%0d exp=9", low_cnt); end
    n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL sweep_other_rows got=%0d exp=0", bad_cnt); end
  endtask

  task automatic test_bounce();
    int done_cnt = 0;
    cols = 4'b1110; pk[0] = 4'h1; ph[0] = 16'd50; pv[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    for (int k = 0; k < 2 * B0 + 50 + G0 + 4; k++) begin
      n_checks++; if (rows_o[0] !== m_rows[0]) begin n_fail++; $display("FAIL bounce_rows k=%0d got=%b exp=%b", k, rows_o[0], m_rows[0]); end
      n_checks++; if (done_o[0] !== m_done[0]) begin n_fail++; $display("FAIL bounce_done k=%0d got=%b exp=%b", k, done_o[0], m_done[0]); end
      n_checks++; if (ready_o[0] !== !m_act[0]) begin n_fail++; $display("FAIL bounce_ready k=%0d got=%b exp=%b", k, ready_o[0], !m_act[0]); end
      if (k >= B0 + 1 && k <= B0 + 50) begin
        n_checks++; if (rows_o[0] !== 4'b1110) begin n_fail++; $display("FAIL bounce_hold_stable k=%0d got=%b exp=1110", k, rows_o[0]); end
      end
      if (done_o[0] === 1'b1) done_cnt++;
      tick();
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bounce_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_ignore_busy();
    int done_cnt = 0;
    cols = 4'b1011; pk[1] = 4'h9; ph[1] = 16'd30; pv[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      n_checks++; if (rows_o[1] !== m_rows[1]) begin n_fail++; $display("FAIL ignore_rows k=%0d got=%b exp=%b", k, rows_o[1], m_rows[1]); end
      if (k >= 5 && k <= 8) begin
        n_checks++; if (ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL ignore_ready k=%0d got=%b exp=0", k, ready_o[1]); end
      end
      if (done_o[1] === 1'b1) done_cnt++;
      if (k >= 5 && k < 8) begin pv[1] = 1'b1; pk[1] = 4'h2; ph[1] = 16'd3; end
      else pv[1] = 1'b0;
      tick();
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    cols = 4'b1011; pk[1] = 4'h6; ph[1] = 16'd30; pv[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    repeat (10) tick();
    n_checks++; if (rows_o[1] !== 4'b1101) begin n_fail++; $display("FAIL midreset_pre_rows got=%b exp=1101", rows_o[1]); end
    reset = 1'b1;
    tick();
    n_checks++; if (rows_o[1] !== 4'hF) begin n_fail++; $display("FAIL midreset_rows got=%b exp=1111", rows_o[1]); end
    n_checks++; if (busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy_o[1]); end
    n_checks++; if (ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_ready_low got=%b exp=0", ready_o[1]); end
    reset = 1'b0;
    tick();
    n_checks++; if (ready_o[1] !== 1'b1) begin n_fail++; $display("FAIL midreset_ready_high got=%b exp=1", ready_o[1]); end
    for (int k = 0; k < 60; k++) begin
      if (done_o[1] === 1'b1) done_cnt++;
      tick();
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int  d;
      bit  saw_done = 1'b0;
      d = (t < 6) ? 1 : 0;
      pk[d] = 4'($urandom_range(0, 15));
      ph[d] = (t == 0) ? 16'd0 : (t == 1) ? 16'd1 : 16'($urandom_range(2, 24));
      cols  = 4'($urandom);
      pv[d] = 1'b1;
      tick();
      for (int k = 0; k < 2000 && !(saw_done && !m_act[d]); k++) begin
        n_checks++; if (rows_o[d] !== m_rows[d]) begin n_fail++; $display("FAIL rand_rows t=%0d k=%0d got=%b exp=%b", t, k, rows_o[d], m_rows[d]); end
        n_checks++; if (done_o[d] !== m_done[d]) begin n_fail++; $display("FAIL rand_done t=%0d k=%0d got=%b exp=%b", t, k, done_o[d], m_done[d]); end
        n_checks++; if (busy_o[d] !== m_act[d]) begin n_fail++; $display("FAIL rand_busy t=%0d k=%0d got=%b exp=%b", t, k, busy_o[d], m_act[d]); end
        n_checks++; if (ready_o[d] !== !m_act[d]) begin n_fail++; $display("FAIL rand_ready t=%0d k=%0d got=%b exp=%b", t, k, ready_o[d], !m_act[d]); end
        if (m_done[d] === 1'b1) saw_done = 1'b1;
        cols  = 4'($urandom);
        pv[d] = m_act[d] ? 1'($urandom_range(0, 1)) : 1'b0;
        pk[d] = 4'($urandom_range(0, 15));
        tick();
      end
      pv[d] = 1'b0;
      n_checks++; if (!saw_done) begin n_fail++; $display("FAIL rand_timeout t=%0d got=no_done exp=done", t); end
    end
  endtask

  // Behavioural column scanner with a multi-scan debounce, driving instance 0.
  task automatic test_scanner();
    int  cand = -1, run = 0, idle_run = 6, val1 = 0, val2 = 0, nreg = 0, hit_key = 0;
    bit  armed = 1'b1, hit = 1'b0;
    for (int k = 0; k < 2200; k++) begin
      int ph4, sc;
      ph4 = k % 4;
      sc  = (k / 4) % 4;
      n_checks++; if (rows_o[0] !== m_rows[0]) begin n_fail++; $display("FAIL scan_rows k=%0d got=%b exp=%b", k, rows_o[0], m_rows[0]); end
      if (ph4 == 3) begin
        for (int r = 0; r < 4; r++) if (rows_o[0][r] == 1'b0) begin hit = 1'b1; hit_key = layout[r * 4 + sc]; end
        if (sc == 3) begin
          if (hit) begin
            idle_run = 0;
            if (hit_key == cand) run++;
            else begin cand = hit_key; run = 1; end
            if (run == 6 && armed) begin val1 = val2; val2 = hit_key; nreg++; armed = 1'b0; end
          end else begin
            run = 0; cand = -1; idle_run++;
            if (idle_run >= 6) armed = 1'b1;
          end
          hit = 1'b0;
        end
      end
      cols  = ~(4'b0001 << sc);
      pv[0] = (k == 0) || (k == 1000);
      pk[0] = (k < 500) ? 4'hA : 4'h7;
      ph[0] = 16'd250;
      tick();
    end
    pv[0] = 1'b0;
    n_checks++; if (nreg != 2) begin n_fail++; $display("FAIL scan_count got=%0d exp=2", nreg); end
    n_checks++; if (val1 != 10) begin n_fail++; $display("FAIL scan_val1 got=%0d exp=10", val1); end
    n_checks++; if (val2 != 7) begin n_fail++; $display("FAIL scan_val2 got=%0d exp=7", val2); end
  endtask

  initial begin
    reset = 1'b1;
    cols  = 4'hF;
    for (int d = 0; d < 2; d++) begin pv[d] = 1'b0; pk[d] = '0; ph[d] = '0; end
    test_reset();
    test_no_bounce();
    test_col_sweep();
    test_bounce();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_scanner();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
